// File: rtl/packet_scheduler_if.sv
// Signal bundle between the packet sources, the scheduler and the data-island assembler.
// The scheduler uses the slave modport; the driving environment uses master.
interface packet_scheduler_if;
  logic              packet_advance;
  logic              acr_tick;
  logic              audio_valid;
  logic              audio_ready;
  logic [23:0]       audio_l;
  logic [23:0]       audio_r;
  logic              aux_valid;
  logic              aux_ready;
  logic [23:0]       aux_header;
  logic [3:0][55:0]  aux_sub;
  logic [23:0]       header;
  logic [3:0][55:0]  sub;
  logic [1:0]        packet_type;

  modport slave (
    input  packet_advance, acr_tick,
    input  audio_valid, audio_l, audio_r,
    input  aux_valid, aux_header, aux_sub,
    output audio_ready, aux_ready,
    output header, sub, packet_type
  );

  modport master (
    output packet_advance, acr_tick,
    output audio_valid, audio_l, audio_r,
    output aux_valid, aux_header, aux_sub,
    input  audio_ready, aux_ready,
    input  header, sub, packet_type
  );
endinterface

// File: rtl/packet_scheduler.sv
// Chooses one packet per data-island slot (ACR, aux InfoFrame, audio samples or null)
// and holds its header and subpackets stable until the next packet_advance.
module packet_scheduler #(
  parameter int          AUDIO_FIFO_DEPTH = 8,
  parameter logic [19:0] ACR_N            = 20'd6144,
  parameter logic [19:0] ACR_CTS          = 20'd25200
) (
  input  logic               clk_pixel,
  input  logic               reset,
  packet_scheduler_if.slave  bus
);
  localparam int AW = $clog2(AUDIO_FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(AUDIO_FIFO_DEPTH);

  localparam logic [55:0] ACR_SUB = {ACR_N[7:0], ACR_N[15:8], 4'b0, ACR_N[19:16],
                                     ACR_CTS[7:0], ACR_CTS[15:8], 4'b0, ACR_CTS[19:16], 8'h00};

  typedef enum logic [1:0] {
    PKT_NULL  = 2'd0,
    PKT_ACR   = 2'd1,
    PKT_AUX   = 2'd2,
    PKT_AUDIO = 2'd3
  } pkt_e;

  // Entry layout: {B (first frame of 192-frame block), right, left}
  logic [48:0]       fifo_mem [AUDIO_FIFO_DEPTH];
  logic [CW-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]     count_reg, count_next;
  logic [7:0]        frame_reg, frame_next;
  logic              acr_pending_reg, acr_pending_next;
  logic [23:0]       header_reg, header_next;
  logic [3:0][55:0]  sub_reg, sub_next;
  pkt_e              type_reg, type_next;

  logic              push;
  logic              pop;
  logic [2:0]        pop_n;
  logic [CW-1:0]     pop_cnt;
  pkt_e              sel;
  logic [3:0][48:0]  peek;
  logic [3:0][55:0]  audio_sub;
  logic [3:0]        present;
  logic [3:0]        bflag;

  assign bus.audio_ready = (count_reg < DEPTH_C);
  assign push            = bus.audio_valid && bus.audio_ready;
  assign pop_n           = (count_reg >= CW'(4)) ? 3'd4 : 3'(count_reg);

  // Up to four oldest entries are formatted in parallel; lanes beyond count read as zero.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [AW-1:0] idx;
      logic [23:0]   smp_l;
      logic [23:0]   smp_r;
      assign idx           = rd_ptr_reg[AW-1:0] + AW'(gi);
      assign peek[gi]      = fifo_mem[idx];
      assign smp_l         = peek[gi][23:0];
      assign smp_r         = peek[gi][47:24];
      assign present[gi]   = (CW'(gi) < count_reg);
      assign bflag[gi]     = present[gi] & peek[gi][48];
      assign audio_sub[gi] = present[gi] ? {^smp_r, 3'b000, ^smp_l, 3'b000, smp_r, smp_l} : 56'd0;
    end
  endgenerate

  always_comb begin
    sel = PKT_NULL;
    if (acr_pending_reg)
      sel = PKT_ACR;
    else if (count_reg == DEPTH_C)
      sel = PKT_AUDIO;
    else if (bus.aux_valid)
      sel = PKT_AUX;
    else if (count_reg != '0)
      sel = PKT_AUDIO;
  end

  assign pop           = bus.packet_advance && (sel == PKT_AUDIO);
  assign pop_cnt       = pop ? CW'(pop_n) : '0;
  assign bus.aux_ready = bus.packet_advance && (sel == PKT_AUX) && !reset;

  always_comb begin
    header_next      = header_reg;
    sub_next         = sub_reg;
    type_next        = type_reg;
    acr_pending_next = acr_pending_reg;
    if (bus.packet_advance) begin
      type_next = sel;
      case (sel)
        PKT_ACR: begin
          header_next      = 24'h000001;
          sub_next         = {4{ACR_SUB}};
          acr_pending_next = 1'b0;
        end
        PKT_AUX: begin
          header_next = bus.aux_header;
          sub_next    = bus.aux_sub;
        end
        PKT_AUDIO: begin
          header_next = {4'b0, bflag, 3'b0, 1'b0, present, 8'h02};
          sub_next    = audio_sub;
        end
        default: begin
          header_next = '0;
          sub_next    = '0;
        end
      endcase
    end
    // A tick in the commit cycle keeps the request alive for the following slot.
    if (bus.acr_tick)
      acr_pending_next = 1'b1;
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg + CW'(push);
    rd_ptr_next = rd_ptr_reg + pop_cnt;
    count_next  = count_reg + CW'(push) - pop_cnt;
    frame_next  = frame_reg;
    if (push)
      frame_next = (frame_reg == 8'd191) ? 8'd0 : frame_reg + 8'd1;
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      frame_reg       <= '0;
      acr_pending_reg <= 1'b0;
      header_reg      <= '0;
      sub_reg         <= '0;
      type_reg        <= PKT_NULL;
    end else begin
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
      count_reg       <= count_next;
      frame_reg       <= frame_next;
      acr_pending_reg <= acr_pending_next;
      header_reg      <= header_next;
      sub_reg         <= sub_next;
      type_reg        <= type_next;
    end
  end

  // Sample storage carries no reset; validity is tracked solely by the pointers.
  always_ff @(posedge clk_pixel) begin
    if (push)
      fifo_mem[wr_ptr_reg[AW-1:0]] <= {(frame_reg == 8'd0), bus.audio_r, bus.audio_l};
  end

  assign bus.header      = header_reg;
  assign bus.sub         = sub_reg;
  assign bus.packet_type = type_reg;
endmodule

// File: tb/tb_packet_scheduler.sv
// Scoreboard bench: expected packets are queued when packet_advance is driven and
// compared against the assembler-facing outputs one cycle later.
module tb_packet_scheduler;
  localparam int DEPTH = 8;
  localparam logic [55:0] ACR_SUB_EXP = 56'h00180070620000;

  typedef struct packed {
    logic        b;
    logic [23:0] r;
    logic [23:0] l;
  } sample_t;

  typedef struct packed {
    logic [1:0]       ptype;
    logic [23:0]      hdr;
    logic [3:0][55:0] sub;
  } pkt_t;

  logic clk_pixel = 1'b0;
  logic reset;
  always #5 clk_pixel = ~clk_pixel;

  packet_scheduler_if bus ();

  packet_scheduler #(
    .AUDIO_FIFO_DEPTH (DEPTH),
    .ACR_N            (20'd6144),
    .ACR_CTS          (20'd25200)
  ) dut (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .bus       (bus)
  );

  sample_t fifo_q[$];
  pkt_t    exp_q[$];
  int      frame_idx;
  bit      acr_pend;
  int      total;
  int      bad;
  int      b_seen;

  task automatic check_value(input string tag, input logic [223:0] got, input logic [223:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    fifo_q.delete();
    exp_q.delete();
    frame_idx = 0;
    acr_pend  = 1'b0;
  endtask

  task automatic clear_inputs();
    bus.packet_advance = 1'b0;
    bus.acr_tick       = 1'b0;
    bus.audio_valid    = 1'b0;
    bus.audio_l        = '0;
    bus.audio_r        = '0;
    bus.aux_valid      = 1'b0;
  endtask

  task automatic step(input bit adv, input bit tick, input bit push,
                      input logic [23:0] l, input logic [23:0] r,
                      input bit auxv, input string tag);
    pkt_t    e;
    sample_t s;
    int      n;
    bit      can_push;
    bit      exp_aux_rdy;
    logic [3:0] pres;
    logic [3:0] bf;
    @(negedge clk_pixel);
    bus.packet_advance = adv;
    bus.acr_tick       = tick;
    bus.audio_valid    = push;
    bus.audio_l        = l;
    bus.audio_r        = r;
    bus.aux_valid      = auxv;
    #1;
    can_push    = (fifo_q.size() < DEPTH);
    exp_aux_rdy = 1'b0;
    check_value({tag, "/audio_ready"}, bus.audio_ready, can_push);
    if (adv) begin
      e = '0;
      if (acr_pend) begin
        e.ptype = 2'd1;
        e.hdr   = 24'h000001;
        for (int i = 0; i < 4; i++) e.sub[i] = ACR_SUB_EXP;
        acr_pend = 1'b0;
      end else if (fifo_q.size() == DEPTH || (!auxv && fifo_q.size() > 0)) begin
        n    = (fifo_q.size() > 4) ? 4 : fifo_q.size();
        pres = '0;
        bf   = '0;
        for (int i = 0; i < n; i++) begin
          s        = fifo_q.pop_front();
          pres[i]  = 1'b1;
          bf[i]    = s.b;
          e.sub[i] = {^s.r, 3'b000, ^s.l, 3'b000, s.r, s.l};
        end
        e.ptype = 2'd3;
        e.hdr   = {4'b0, bf, 3'b0, 1'b0, pres, 8'h02};
      end else if (auxv) begin
        e.ptype     = 2'd2;
        e.hdr       = bus.aux_header;
        e.sub       = bus.aux_sub;
        exp_aux_rdy = 1'b1;
      end
      exp_q.push_back(e);
    end
    check_value({tag, "/aux_ready"}, bus.aux_ready, exp_aux_rdy);
    if (tick) acr_pend = 1'b1;
    if (push && can_push) begin
      fifo_q.push_back({(frame_idx == 0), r, l});
      frame_idx = (frame_idx == 191) ? 0 : frame_idx + 1;
    end
    @(posedge clk_pixel);
    #1;
    clear_inputs();
    if (adv) begin
      e = exp_q.pop_front();
      $display("pkt %s type=%0d header=%06h", tag, bus.packet_type, bus.header);
      check_value({tag, "/type"}, bus.packet_type, e.ptype);
      check_value({tag, "/header"}, bus.header, e.hdr);
      check_value({tag, "/sub"}, bus.sub, e.sub);
      if (bus.packet_type == 2'd3) b_seen += $countones(bus.header[19:16]);
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    b_seen = 0;
    clear_inputs();
    bus.aux_header = 24'h8A1234;
    for (int i = 0; i < 4; i++) bus.aux_sub[i] = {8'hA0 + 8'(i), 48'h0123456789AB};
    reset = 1'b1;
    model_reset();
    repeat (3) @(posedge clk_pixel);
    #1;
    check_value("rst/header", bus.header, 24'h0);
    check_value("rst/sub", bus.sub, 224'h0);
    check_value("rst/type", bus.packet_type, 2'd0);
    check_value("rst/aux_ready", bus.aux_ready, 1'b0);
    check_value("rst/audio_ready", bus.audio_ready, 1'b1);
    @(negedge clk_pixel);
    reset = 1'b0;

    // Idle slot, then ACR
    step(1, 0, 0, 24'h0, 24'h0, 0, "null");
    step(0, 1, 0, 24'h0, 24'h0, 0, "tick");
    step(1, 0, 0, 24'h0, 24'h0, 0, "acr");
    step(1, 0, 0, 24'h0, 24'h0, 0, "acr_cleared");

    // Six samples drained as 4 + 2
    for (int k = 0; k < 6; k++) step(0, 0, 1, 24'h000001 + 24'(k), 24'h800000, 0, "push6");
    step(1, 0, 0, 24'h0, 24'h0, 0, "audio4");
    step(1, 0, 0, 24'h0, 24'h0, 0, "audio2");
    step(1, 0, 0, 24'h0, 24'h0, 0, "drained");

    // Full FIFO beats aux; aux wins once below full; push/pop overlap
    for (int k = 0; k < 8; k++) step(0, 0, 1, 24'h100 + 24'(k), 24'h0F0F0F, 1, "fill");
    step(0, 0, 1, 24'hDEAD00, 24'hBEEF00, 1, "push_full");
    step(1, 0, 1, 24'hDEAD01, 24'hBEEF01, 1, "full_audio");
    step(1, 0, 0, 24'h0, 24'h0, 1, "aux");
    step(1, 0, 1, 24'h777777, 24'h000003, 0, "pop_push");
    step(1, 0, 0, 24'h0, 24'h0, 0, "audio_last");

    // Tick coincident with ACR commit keeps the request pending
    step(0, 1, 0, 24'h0, 24'h0, 0, "tick2");
    step(1, 1, 0, 24'h0, 24'h0, 0, "acr_coinc");
    step(1, 0, 0, 24'h0, 24'h0, 0, "acr_again");
    step(1, 0, 0, 24'h0, 24'h0, 0, "null2");

    // Block-start flag across a 192-frame wrap
    @(negedge clk_pixel);
    reset = 1'b1;
    model_reset();
    @(negedge clk_pixel);
    reset  = 1'b0;
    b_seen = 0;
    for (int k = 0; k < 193; k++)
      step((k % 4) == 3, 0, 1, 24'(k * 3), 24'(~k), 0, "bloop");
    step(1, 0, 0, 24'h0, 24'h0, 0, "bdrain");
    step(1, 0, 0, 24'h0, 24'h0, 0, "bdrain");
    check_value("b_flag_count", b_seen, 2);

    // Asynchronous reset with samples buffered
    step(0, 1, 0, 24'h0, 24'h0, 0, "tick3");
    step(1, 0, 0, 24'h0, 24'h0, 0, "acr3");
    for (int k = 0; k < 5; k++) step(0, 0, 1, 24'h55 + 24'(k), 24'h66, 0, "push5");
    @(negedge clk_pixel);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_value("async/header", bus.header, 24'h0);
    check_value("async/sub", bus.sub, 224'h0);
    check_value("async/type", bus.packet_type, 2'd0);
    check_value("async/audio_ready", bus.audio_ready, 1'b1);
    @(negedge clk_pixel);
    reset = 1'b0;
    step(1, 0, 0, 24'h0, 24'h0, 0, "post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
